// File: rtl/flip_vector_reg.sv
// Flip-N-Write storage register: picks plain or inverted encoding per write to
// minimise toggled cells, presents the decoded word and keeps toggle statistics.
module flip_vector_reg #(
  parameter int N     = 16,
  parameter int CNT_W = 8,
  parameter int ACC_W = 16,
  parameter int MODE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     clr_cnt,
  input  logic [N-1:0]             d,
  output logic [N-1:0]             q_enc,
  output logic                     flip,
  output logic [N-1:0]             q,
  output logic [$clog2(N+2)-1:0]   last_tog,
  output logic [CNT_W-1:0]         flip_count,
  output logic [ACC_W-1:0]         toggle_acc
);

  localparam int PC_W  = $clog2(N+1);
  localparam int TOG_W = $clog2(N+2);
  localparam int SUM_W = ((ACC_W > TOG_W) ? ACC_W : TOG_W) + 1;

  logic [N-1:0]     q_enc_q, q_enc_d;
  logic             flip_q, flip_d;
  logic [TOG_W-1:0] last_tog_q, last_tog_d;
  logic [CNT_W-1:0] flip_count_q, flip_count_d;
  logic [ACC_W-1:0] toggle_acc_q, toggle_acc_d;

  logic [PC_W-1:0]  h;
  logic [TOG_W-1:0] c_pl;
  logic [TOG_W-1:0] c_inv;
  logic [TOG_W-1:0] tog_new;
  logic             inv;
  logic [SUM_W-1:0] acc_sum;

  always_comb begin
    h = '0;
    for (int i = 0; i < N; i++) begin
      h = h + PC_W'(d[i] ^ q_enc_q[i]);
    end
  end

  // The flag cell is counted as a toggle too, so each cost includes its change.
  always_comb begin
    c_pl    = TOG_W'(h) + TOG_W'(flip_q);
    c_inv   = TOG_W'(N) - TOG_W'(h) + TOG_W'(!flip_q);
    inv     = (MODE != 0) && (c_inv < c_pl);
    tog_new = inv ? c_inv : c_pl;
    acc_sum = SUM_W'(toggle_acc_q) + SUM_W'(tog_new);
  end

  always_comb begin
    q_enc_d      = q_enc_q;
    flip_d       = flip_q;
    last_tog_d   = last_tog_q;
    flip_count_d = flip_count_q;
    toggle_acc_d = toggle_acc_q;

    if (wr_en) begin
      q_enc_d    = inv ? ~d : d;
      flip_d     = inv;
      last_tog_d = tog_new;
    end

    if (clr_cnt) begin
      flip_count_d = '0;
      toggle_acc_d = '0;
    end else if (wr_en) begin
      if (inv && (flip_count_q != '1)) begin
        flip_count_d = flip_count_q + CNT_W'(1);
      end
      if (acc_sum > SUM_W'({ACC_W{1'b1}})) begin
        toggle_acc_d = '1;
      end else begin
        toggle_acc_d = ACC_W'(acc_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_enc_q      <= '0;
      flip_q       <= 1'b0;
      last_tog_q   <= '0;
      flip_count_q <= '0;
      toggle_acc_q <= '0;
    end else begin
      q_enc_q      <= q_enc_d;
      flip_q       <= flip_d;
      last_tog_q   <= last_tog_d;
      flip_count_q <= flip_count_d;
      toggle_acc_q <= toggle_acc_d;
    end
  end

  assign q_enc      = q_enc_q;
  assign flip       = flip_q;
  assign q          = q_enc_q ^ {N{flip_q}};
  assign last_tog   = last_tog_q;
  assign flip_count = flip_count_q;
  assign toggle_acc = toggle_acc_q;

endmodule

// File: tb/tb_flip_vector_reg.sv
// Scoreboard bench for flip_vector_reg: three parameterisations share one
// stimulus stream, each compared against its own behavioural model.
module tb_flip_vector_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrEn = 1'b0;
  logic        clrCnt = 1'b0;
  logic [15:0] d = '0;

  int checks = 0;
  int failures = 0;

  logic [15:0] mainQEnc, mainQ;
  logic        mainFlip;
  logic [4:0]  mainLastTog;
  logic [7:0]  mainFlipCount;
  logic [15:0] mainToggleAcc;

  logic [15:0] cnt2QEnc, cnt2Q;
  logic        cnt2Flip;
  logic [4:0]  cnt2LastTog;
  logic [1:0]  cnt2FlipCount;
  logic [15:0] cnt2ToggleAcc;

  logic [15:0] acc3QEnc, acc3Q;
  logic        acc3Flip;
  logic [4:0]  acc3LastTog;
  logic [7:0]  acc3FlipCount;
  logic [2:0]  acc3ToggleAcc;

  typedef struct {
    logic [15:0] qEnc;
    bit          flip;
    int          lastTog;
    int          flipCount;
    int          toggleAcc;
  } modelT;

  modelT modelState[3];
  modelT expQueue[$];

  always #5 clk = ~clk;

  flip_vector_reg #(.N(16), .CNT_W(8), .ACC_W(16), .MODE(1)) u_main (
    .clk(clk), .rst(rst), .wr_en(wrEn), .clr_cnt(clrCnt), .d(d),
    .q_enc(mainQEnc), .flip(mainFlip), .q(mainQ), .last_tog(mainLastTog),
    .flip_count(mainFlipCount), .toggle_acc(mainToggleAcc)
  );

  flip_vector_reg #(.N(16), .CNT_W(2), .ACC_W(16), .MODE(1)) u_cnt2 (
    .clk(clk), .rst(rst), .wr_en(wrEn), .clr_cnt(clrCnt), .d(d),
    .q_enc(cnt2QEnc), .flip(cnt2Flip), .q(cnt2Q), .last_tog(cnt2LastTog),
    .flip_count(cnt2FlipCount), .toggle_acc(cnt2ToggleAcc)
  );

  flip_vector_reg #(.N(16), .CNT_W(8), .ACC_W(3), .MODE(0)) u_acc3 (
    .clk(clk), .rst(rst), .wr_en(wrEn), .clr_cnt(clrCnt), .d(d),
    .q_enc(acc3QEnc), .flip(acc3Flip), .q(acc3Q), .last_tog(acc3LastTog),
    .flip_count(acc3FlipCount), .toggle_acc(acc3ToggleAcc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the cost definitions, one instance at a time.
  function automatic modelT stepModel(input modelT s, input bit rstI, input bit wrI,
                                      input bit clrI, input logic [15:0] dI,
                                      input int mode, input int cntMax, input int accMax);
    modelT n;
    int h, costPlain, costInv, tog;
    bit inv;
    n = s;
    if (rstI) begin
      n.qEnc = '0; n.flip = 0; n.lastTog = 0; n.flipCount = 0; n.toggleAcc = 0;
      return n;
    end
    inv = 0;
    tog = 0;
    if (wrI) begin
      h = $countones(dI ^ s.qEnc);
      costPlain = h + (s.flip ? 1 : 0);
      costInv = (16 - h) + (s.flip ? 0 : 1);
      inv = (mode == 1) && (costInv < costPlain);
      tog = inv ? costInv : costPlain;
      n.qEnc = inv ? ~dI : dI;
      n.flip = inv;
      n.lastTog = tog;
    end
    if (clrI) begin
      n.flipCount = 0;
      n.toggleAcc = 0;
    end else if (wrI) begin
      if (inv) n.flipCount = (s.flipCount + 1 > cntMax) ? cntMax : s.flipCount + 1;
      n.toggleAcc = (s.toggleAcc + tog > accMax) ? accMax : s.toggleAcc + tog;
    end
    return n;
  endfunction

  task automatic compareInstance(input string name, input modelT e, input logic [15:0] qEnc,
                                 input logic fl, input logic [15:0] qq, input logic [4:0] lt,
                                 input logic [31:0] fc, input logic [31:0] ta);
    checkOutput({name, ".q_enc"}, 32'(qEnc), 32'(e.qEnc));
    checkOutput({name, ".flip"}, 32'(fl), 32'(e.flip));
    checkOutput({name, ".q"}, 32'(qq), 32'(e.qEnc ^ {16{e.flip}}));
    checkOutput({name, ".last_tog"}, 32'(lt), 32'(e.lastTog));
    checkOutput({name, ".flip_count"}, fc, 32'(e.flipCount));
    checkOutput({name, ".toggle_acc"}, ta, 32'(e.toggleAcc));
  endtask

  task automatic applyStimulus(input bit rstI, input bit wrI, input bit clrI, input logic [15:0] dI);
    rst = rstI; wrEn = wrI; clrCnt = clrI; d = dI;
    modelState[0] = stepModel(modelState[0], rstI, wrI, clrI, dI, 1, 255, 65535);
    modelState[1] = stepModel(modelState[1], rstI, wrI, clrI, dI, 1, 3, 65535);
    modelState[2] = stepModel(modelState[2], rstI, wrI, clrI, dI, 0, 255, 7);
    for (int i = 0; i < 3; i++) expQueue.push_back(modelState[i]);
    @(posedge clk);
    #1;
    compareInstance("main", expQueue.pop_front(), mainQEnc, mainFlip, mainQ, mainLastTog,
                    32'(mainFlipCount), 32'(mainToggleAcc));
    compareInstance("cnt2", expQueue.pop_front(), cnt2QEnc, cnt2Flip, cnt2Q, cnt2LastTog,
                    32'(cnt2FlipCount), 32'(cnt2ToggleAcc));
    compareInstance("acc3", expQueue.pop_front(), acc3QEnc, acc3Flip, acc3Q, acc3LastTog,
                    32'(acc3FlipCount), 32'(acc3ToggleAcc));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) modelState[i] = '{16'h0, 1'b0, 0, 0, 0};

    // Reset with random data and a write strobe present
    applyStimulus(1, 1, 0, 16'($urandom));
    applyStimulus(1, 1, 1, 16'($urandom));
    checkOutput("reset.q", 32'(mainQ), 32'h0);
    checkOutput("reset.flip_count", 32'(mainFlipCount), 32'h0);

    applyStimulus(0, 1, 0, 16'h00FF);
    checkOutput("w00ff.q_enc", 32'(mainQEnc), 32'h00FF);
    checkOutput("w00ff.last_tog", 32'(mainLastTog), 32'd8);
    checkOutput("w00ff.flip", 32'(mainFlip), 32'd0);

    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 16'hFFFF);
    checkOutput("wffff.q_enc", 32'(mainQEnc), 32'h0000);
    checkOutput("wffff.q", 32'(mainQ), 32'hFFFF);
    checkOutput("wffff.last_tog", 32'(mainLastTog), 32'd1);
    checkOutput("wffff.flip_count", 32'(mainFlipCount), 32'd1);
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("w0000.flip", 32'(mainFlip), 32'd0);
    checkOutput("w0000.last_tog", 32'(mainLastTog), 32'd1);
    checkOutput("w0000.toggle_acc", 32'(mainToggleAcc), 32'd2);

    // Hold and clear-only cycles
    applyStimulus(0, 0, 0, 16'hBEEF);
    applyStimulus(0, 0, 1, 16'h1234);

    // Saturation: alternating full-width writes
    applyStimulus(1, 0, 0, 16'h0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, (i % 2 == 0) ? 16'hFFFF : 16'h0000);
    checkOutput("sat.cnt2_flip_count", 32'(cnt2FlipCount), 32'd3);
    checkOutput("sat.acc3_toggle_acc", 32'(acc3ToggleAcc), 32'd7);

    // Write and counter clear in the same cycle
    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(0, 1, 1, 16'hFFFF);
    checkOutput("wclr.q", 32'(mainQ), 32'hFFFF);
    checkOutput("wclr.flip", 32'(mainFlip), 32'd1);
    checkOutput("wclr.last_tog", 32'(mainLastTog), 32'd1);
    checkOutput("wclr.flip_count", 32'(mainFlipCount), 32'd0);
    checkOutput("wclr.toggle_acc", 32'(mainToggleAcc), 32'd0);

    // Bypass instance, then reset overriding a write
    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 16'hFFFF);
    checkOutput("byp.q_enc", 32'(acc3QEnc), 32'hFFFF);
    checkOutput("byp.flip", 32'(acc3Flip), 32'd0);
    checkOutput("byp.last_tog", 32'(acc3LastTog), 32'd16);
    applyStimulus(1, 1, 0, 16'h1234);
    checkOutput("rstwr.q_enc", 32'(acc3QEnc), 32'h0);
    checkOutput("rstwr.main_q", 32'(mainQ), 32'h0);

    // Random traffic, mostly back-to-back writes
    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
